// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative unsigned MUL/MULHU/DIVU/REMU unit feeding the RF write port.
// Revision : 1.0
// ============================================================================
module muldiv_unit #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [1:0]               op,
   input  logic [DATA_WIDTH-1:0]    rs1_val,
   input  logic [DATA_WIDTH-1:0]    rs2_val,
   input  logic [ADDRESS_WIDTH-1:0] rd_in,
   output logic                     busy,
   output logic                     done,
   output logic [DATA_WIDTH-1:0]    result,
   output logic [ADDRESS_WIDTH-1:0] rd_out
);

   localparam int                CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [1:0]        C_MUL   = 2'b00;
   localparam logic [1:0]        C_MULHU = 2'b01;
   localparam logic [1:0]        C_DIVU  = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                      r_state;
   logic [CNT_W-1:0]            r_cnt;
   logic [1:0]                  r_op;
   logic [ADDRESS_WIDTH-1:0]    r_rd;
   logic [DATA_WIDTH-1:0]       r_b;
   logic [2*DATA_WIDTH-1:0]     r_prod;
   logic [DATA_WIDTH-1:0]       r_rem;
   logic [DATA_WIDTH-1:0]       r_quo;
   logic                        r_busy;
   logic                        r_done;
   logic [DATA_WIDTH-1:0]       r_result;
   logic [ADDRESS_WIDTH-1:0]    r_rd_out;

   logic [DATA_WIDTH:0]         w_add;
   logic [2*DATA_WIDTH-1:0]     w_prod_nxt;
   logic [DATA_WIDTH:0]         w_shift;
   logic                        w_ge;
   logic [DATA_WIDTH-1:0]       w_diff;
   logic [DATA_WIDTH-1:0]       w_rem_nxt;
   logic [DATA_WIDTH-1:0]       w_quo_nxt;
   logic [DATA_WIDTH-1:0]       w_res;

   // Shift-add: the low half of r_prod starts as the multiplier and drains out LSB first.
   assign w_add      = {1'b0, r_prod[2*DATA_WIDTH-1:DATA_WIDTH]}
                     + (r_prod[0] ? {1'b0, r_b} : {(DATA_WIDTH+1){1'b0}});
   assign w_prod_nxt = {w_add, r_prod[DATA_WIDTH-1:1]};

   // Restoring division with a DATA_WIDTH+1 bit partial remainder; a zero divisor
   // naturally yields an all-ones quotient and the dividend as remainder.
   assign w_shift    = {r_rem, r_quo[DATA_WIDTH-1]};
   assign w_ge       = (w_shift >= {1'b0, r_b});
   assign w_diff     = w_shift[DATA_WIDTH-1:0] - r_b;
   assign w_rem_nxt  = w_ge ? w_diff : w_shift[DATA_WIDTH-1:0];
   assign w_quo_nxt  = {r_quo[DATA_WIDTH-2:0], w_ge};

   always_comb begin
      w_res = w_rem_nxt;
      case (r_op)
         C_MUL:   w_res = w_prod_nxt[DATA_WIDTH-1:0];
         C_MULHU: w_res = w_prod_nxt[2*DATA_WIDTH-1:DATA_WIDTH];
         C_DIVU:  w_res = w_quo_nxt;
         default: w_res = w_rem_nxt;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_op     <= '0;
         r_rd     <= '0;
         r_b      <= '0;
         r_prod   <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_rd_out <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               r_busy <= 1'b0;
               if (start) begin
                  r_op    <= op;
                  r_rd    <= rd_in;
                  r_b     <= rs2_val;
                  r_prod  <= {{DATA_WIDTH{1'b0}}, rs1_val};
                  r_quo   <= rs1_val;
                  r_rem   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_prod <= w_prod_nxt;
               r_rem  <= w_rem_nxt;
               r_quo  <= w_quo_nxt;
               r_cnt  <= r_cnt + CNT_W'(1);
               if (r_cnt == C_LAST) begin
                  r_result <= w_res;
                  r_rd_out <= r_rd;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
   assign rd_out = r_rd_out;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative unsigned multiply/divide unit for RV32 M-style operations.
- Sits directly downstream of the register file: consumes the RD1/RD2 operand pair and the destination register address.
- Produces a result, destination address and one-cycle write-enable pulse that feed the register file write port (WD3/AD3/WE3).
- Multi-cycle: the issuing control logic stalls while busy is high.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH
ADDRESS_WIDTH, 5, destination register address width

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU
rs1_val  input  DATA_WIDTH  operand A / dividend (from RD1)
rs2_val  input  DATA_WIDTH  operand B / divisor (from RD2)
rd_in  input  ADDRESS_WIDTH  destination register for this request
busy  output  1  high while an operation is in progress
done  output  1  one-cycle completion pulse; drives WE3
result  output  DATA_WIDTH  operation result; drives WD3
rd_out  output  ADDRESS_WIDTH  destination captured at start; drives AD3

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, result=0, rd_out=0.
  - Iteration counter and all datapath registers cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On a rising edge with start=1: capture op, rs1_val, rs2_val, rd_in; counter=0; go to RUN.
- RUN:
  - busy=1, done=0.
  - One iteration per rising edge, exactly DATA_WIDTH iterations.
  - After the edge completing iteration DATA_WIDTH, go to DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle, then IDLE.
- Latency: start sampled at edge N, so busy=1 from edge N to N+DATA_WIDTH; done=1 between edges N+DATA_WIDTH and N+DATA_WIDTH+1.
  - Latency is fixed at DATA_WIDTH+1 edges for every op, including corner cases. No early termination.
- Multiply:
  - Shift-add over a 2*DATA_WIDTH product register; unsigned operands.
  - MUL returns product[DATA_WIDTH-1:0]; MULHU returns product[2*DATA_WIDTH-1:DATA_WIDTH].
- Divide:
  - Restoring division; the partial remainder is DATA_WIDTH+1 bits wide, so no overflow is possible.
  - DIVU returns the quotient; REMU returns the remainder.
- Divide by zero: DIVU returns all-ones (0xFFFFFFFF); REMU returns rs1_val. No exception, same latency.
- result and rd_out update on entry to DONE and hold until the next accepted start.
- result is don't-care-free: it is stable and valid whenever done=1.
- start while busy=1 or in DONE: ignored, not queued; operands in flight unaffected.
- Input operand changes after the start edge have no effect.
- Reset mid-RUN: abort immediately to IDLE; no done pulse; result/rd_out cleared to 0.
- rd_in=0 is passed through unchanged. Suppressing writes to x0 is the register file's job.

Test Plan:
- MUL 7 x 6, rd_in=5 -> busy for 32 cycles; done pulse exactly 33 edges after start edge; result=0x0000002A, rd_out=5.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE; same operands with MUL -> result=0x00000001.
- DIVU 100/7 -> result=0x0000000E; REMU 100/7 -> result=0x00000002; DIVU 5/9 -> result=0.
- DIVU 0x12345678/0 -> result=0xFFFFFFFF; REMU 0x12345678/0 -> result=0x12345678; latency still 33.
- start pulsed with different operands at cycles 3 and 20 of a RUN -> ignored; exactly one done pulse with the original result; start asserted the cycle after done returns IDLE is accepted.
- rst asserted asynchronously mid-RUN (between clock edges) -> busy/done/result/rd_out go to 0 without waiting for clk; no done pulse afterwards; a new start after rst deasserts completes normally.
